// File: rtl/freq_meter_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the frequency meter.
package freq_meter_pkg;

   localparam int unsigned DEFAULT_GATE_CYCLES = 32'd50000000;
   localparam int unsigned DEFAULT_EDGE_W      = 32'd27;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   // Gate counter width; a one-cycle window still needs a one-bit counter.
   function automatic int unsigned gate_width(input int unsigned cycles);
      return (cycles > 32'd1) ? $clog2(cycles) : 32'd1;
   endfunction

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// Two-flop synchronizer plus previous-value register; emits a one-cycle rise pulse.
module sync_edge_detect (
   input  logic speed_clock,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Synchronizer chain and delayed copy for edge detection
   always_ff @(posedge speed_clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= async_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts sig_in rising edges over GATE_CYCLES clocks.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
   parameter int unsigned EDGE_W      = DEFAULT_EDGE_W
) (
   input  logic              speed_clock,
   input  logic              reset,
   input  logic              sig_in,
   input  logic              start,
   input  logic              continuous,
   output logic [EDGE_W-1:0] freq_count,
   output logic              valid,
   output logic              busy,
   output logic              overflow
);

   localparam int unsigned       GW        = gate_width(GATE_CYCLES);
   localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 32'd1);
   localparam logic [GW-1:0]     GATE_ONE  = GW'(32'd1);
   localparam logic [EDGE_W-1:0] EDGE_MAX  = {EDGE_W{1'b1}};
   localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(32'd1);

   state_e            state_q, state_d;
   logic [GW-1:0]     gate_q, gate_d;
   logic [EDGE_W-1:0] edge_q, edge_d;
   logic [EDGE_W-1:0] freq_q, freq_d;
   logic              sat_q, sat_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;
   logic              rise_s;

   sync_edge_detect u_sync (
      .speed_clock (speed_clock),
      .reset       (reset),
      .async_in    (sig_in),
      .rise        (rise_s)
   );

   // Next-state logic; results are captured on the MEASURE->DONE transition so
   // they are visible on the outputs exactly during the DONE cycle.
   always_comb begin
      state_d = state_q;
      gate_d  = gate_q;
      edge_d  = edge_q;
      sat_d   = sat_q;
      freq_d  = freq_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_MEASURE;
               gate_d  = {GW{1'b0}};
               edge_d  = {EDGE_W{1'b0}};
               sat_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MEASURE: begin
            gate_d = gate_q + GATE_ONE;
            if (rise_s) begin
               if (edge_q == EDGE_MAX) begin
                  sat_d = 1'b1;
               end else begin
                  edge_d = edge_q + EDGE_ONE;
               end
            end else begin
               edge_d = edge_q;
            end
            // The final window cycle still counts its edge before capture
            if (gate_q == GATE_LAST) begin
               state_d = ST_DONE;
               gate_d  = {GW{1'b0}};
               freq_d  = edge_d;
               ovf_d   = sat_d;
               valid_d = 1'b1;
            end else begin
               state_d = ST_MEASURE;
            end
         end
         ST_DONE: begin
            if (continuous) begin
               state_d = ST_MEASURE;
               gate_d  = {GW{1'b0}};
               edge_d  = {EDGE_W{1'b0}};
               sat_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge speed_clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         gate_q  <= {GW{1'b0}};
         edge_q  <= {EDGE_W{1'b0}};
         sat_q   <= 1'b0;
         freq_q  <= {EDGE_W{1'b0}};
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gate_q  <= gate_d;
         edge_q  <= edge_d;
         sat_q   <= sat_d;
         freq_q  <= freq_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign freq_count = freq_q;
   assign overflow   = ovf_q;
   assign valid      = valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter with a 100-cycle gate window.
module tb_freq_meter;

   logic        clk;
   logic        reset;
   logic        sig_in, sig_in2;
   logic        start, start2;
   logic        cont;
   logic [26:0] freq;
   logic [3:0]  freq2;
   logic        valid, valid2, busy, busy2, ovf, ovf2;

   int tests;
   int fails;
   int per1, per2;
   int n, m, low, pulses;

   freq_meter #(.GATE_CYCLES(100), .EDGE_W(27)) dut (
      .speed_clock (clk),
      .reset       (reset),
      .sig_in      (sig_in),
      .start       (start),
      .continuous  (cont),
      .freq_count  (freq),
      .valid       (valid),
      .busy        (busy),
      .overflow    (ovf)
   );

   freq_meter #(.GATE_CYCLES(100), .EDGE_W(4)) dut_sat (
      .speed_clock (clk),
      .reset       (reset),
      .sig_in      (sig_in2),
      .start       (start2),
      .continuous  (1'b0),
      .freq_count  (freq2),
      .valid       (valid2),
      .busy        (busy2),
      .overflow    (ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Periodic stimulus sources (period 0 holds the line low)
   initial begin
      int ph1, ph2;
      ph1 = 0;
      ph2 = 0;
      sig_in  = 1'b0;
      sig_in2 = 1'b0;
      forever begin
         @(negedge clk);
         if (per1 == 0) begin
            sig_in = 1'b0;
            ph1 = 0;
         end else begin
            sig_in = (ph1 < per1 / 2);
            ph1 = (ph1 + 1) % per1;
         end
         if (per2 == 0) begin
            sig_in2 = 1'b0;
            ph2 = 0;
         end else begin
            sig_in2 = (ph2 < per2 / 2);
            ph2 = (ph2 + 1) % per2;
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse start on one meter and count cycles until its valid appears
   task automatic run_meas(input int which, input int limit, output int cnt);
      if (which == 0) start = 1'b1;
      else start2 = 1'b1;
      cnt = 0;
      do begin
         tick(1);
         cnt++;
         start  = 1'b0;
         start2 = 1'b0;
      end while (((which == 0) ? valid : valid2) !== 1'b1 && cnt < limit);
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      per1   = 10;
      per2   = 0;
      reset  = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;
      cont   = 1'b0;

      tick(3);
      chk("rst_freq", 32'(freq), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      reset = 1'b0;
      tick(20);
      chk("idle_after_rst", 32'(busy), 32'd0);

      // Single shot, period 10
      run_meas(0, 300, n);
      chk("single_latency", 32'(n), 32'd101);
      chk("single_freq", 32'(freq), 32'd10);
      chk("single_ovf", 32'(ovf), 32'd0);
      chk("single_busy_done", 32'(busy), 32'd1);
      tick(1);
      chk("single_valid_pulse", 32'(valid), 32'd0);
      chk("single_busy_drop", 32'(busy), 32'd0);

      // No input activity
      per1 = 0;
      tick(5);
      run_meas(0, 300, n);
      chk("zero_latency", 32'(n), 32'd101);
      chk("zero_freq", 32'(freq), 32'd0);
      chk("zero_ovf", 32'(ovf), 32'd0);

      // Saturation with 4-bit counter, 25 edges in the window
      per2 = 4;
      tick(10);
      run_meas(1, 300, n);
      chk("sat_latency", 32'(n), 32'd101);
      chk("sat_freq", 32'(freq2), 32'd15);
      chk("sat_ovf", 32'(ovf2), 32'd1);
      chk("hold_freq", 32'(freq), 32'd0);

      // Continuous mode
      per1 = 10;
      cont = 1'b1;
      tick(20);
      run_meas(0, 300, n);
      chk("cont_first", 32'(n), 32'd101);
      chk("cont_freq0", 32'((freq == 27'd9) || (freq == 27'd10)), 32'd1);
      for (int k = 0; k < 2; k++) begin
         m = 0;
         low = 0;
         do begin
            tick(1);
            m++;
            if (busy !== 1'b1) low = 1;
         end while (valid !== 1'b1 && m < 300);
         chk("cont_period", 32'(m), 32'd101);
         chk("cont_busy_high", 32'(low), 32'd0);
         chk("cont_freq", 32'((freq == 27'd9) || (freq == 27'd10)), 32'd1);
      end
      tick(1);
      m = 1;
      cont = 1'b0;
      do begin
         tick(1);
         m++;
      end while (valid !== 1'b1 && m < 300);
      chk("cont_stop_period", 32'(m), 32'd101);
      tick(1);
      chk("cont_stop_busy", 32'(busy), 32'd0);
      chk("cont_stop_freq", 32'(freq), 32'd10);

      // Reset in the middle of a window
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(49);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_freq", 32'(freq), 32'd0);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ovf", 32'(ovf), 32'd0);
      tick(3);
      reset = 1'b0;
      pulses = 0;
      low = 0;
      for (int k = 0; k < 150; k++) begin
         tick(1);
         if (valid === 1'b1) pulses++;
         if (busy !== 1'b0) low++;
      end
      chk("midrst_no_valid", 32'(pulses), 32'd0);
      chk("midrst_stays_idle", 32'(low), 32'd0);

      // start held through the window
      start = 1'b1;
      n = 0;
      pulses = 0;
      do begin
         tick(1);
         n++;
      end while (valid !== 1'b1 && n < 300);
      chk("held_latency", 32'(n), 32'd101);
      chk("held_freq", 32'(freq), 32'd10);
      tick(1);
      chk("held_idle_valid", 32'(valid), 32'd0);
      chk("held_idle_busy", 32'(busy), 32'd0);
      tick(1);
      chk("held_restart_busy", 32'(busy), 32'd1);
      start = 1'b0;
      n = 0;
      do begin
         tick(1);
         n++;
         if (valid === 1'b1) pulses++;
      end while (valid !== 1'b1 && n < 300);
      chk("held_second_latency", 32'(n), 32'd100);
      chk("held_second_pulses", 32'(pulses), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
